// File: rtl/bcd_count_pkg.sv
// Shared types and constants for the cascaded BCD counter.
// bcd_next() is the single definition of one digit's next-state rule.
package bcd_count_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX  = 4'd9;
    localparam bcd_digit_t BCD_ZERO = 4'd0;

    // Out-of-range codes (10-15) fall back to zero whether or not inc is set
    function automatic bcd_digit_t bcd_next(input bcd_digit_t d, input logic inc);
        bcd_digit_t r;
        r = d;
        if (d > BCD_MAX) begin
            r = BCD_ZERO;
        end else if (inc) begin
            r = (d == BCD_MAX) ? BCD_ZERO : d + 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One modulo-10 BCD digit with ripple-carry output.
// carry_out is suppressed while the digit holds an illegal code.
module bcd_digit
    import bcd_count_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       inc_in,
    output bcd_digit_t digit,
    output logic       carry_out
);

    bcd_digit_t digit_q;
    bcd_digit_t digit_d;

    always_comb begin
        digit_d = bcd_next(digit_q, inc_in);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            digit_q <= BCD_ZERO;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit     = digit_q;
    assign carry_out = inc_in && (digit_q == BCD_MAX);

endmodule

// File: rtl/bcd_count.sv
// Free-running NUM_DIGITS-digit BCD counter with terminal-count decode
// and a registered pulse the cycle after rolling over to zero.
module bcd_count
    import bcd_count_pkg::*;
#(
    parameter int NUM_DIGITS = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic [4*NUM_DIGITS-1:0] count,
    output logic                    tc,
    output logic                    wrap
);

    logic [NUM_DIGITS:0]   carry;
    logic [NUM_DIGITS-1:0] is_nine;
    logic                  wrap_q;
    logic                  wrap_d;

    // Digit 0 always increments; the chain carries only through all-nines
    assign carry[0] = 1'b1;

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
        bcd_digit_t digit_w;

        bcd_digit u_digit (
            .clk      (clk),
            .rst      (rst),
            .inc_in   (carry[k]),
            .digit    (digit_w),
            .carry_out(carry[k+1])
        );

        assign count[4*k +: 4] = digit_w;
        assign is_nine[k]      = (digit_w == BCD_MAX);
    end

    assign tc = &is_nine;

    // Carry out of the top digit is exactly the all-nines -> zero edge
    assign wrap_d = carry[NUM_DIGITS];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= wrap_d;
        end
    end

    assign wrap = wrap_q;

endmodule

// File: tb/tb_bcd_count.sv
// Directed/randomized bench for bcd_count at 1, 2 and 3 digits, checked
// against a decimal-integer reference model.
module tb_bcd_count;

    logic        clk = 1'b0;
    logic        rst1, rst2, rst3;
    logic [3:0]  count1;
    logic [7:0]  count2;
    logic [11:0] count3;
    logic        tc1, tc2, tc3;
    logic        wrap1, wrap2, wrap3;

    bcd_count #(.NUM_DIGITS(1)) dut1 (.clk(clk), .rst(rst1), .count(count1), .tc(tc1), .wrap(wrap1));
    bcd_count #(.NUM_DIGITS(2)) dut2 (.clk(clk), .rst(rst2), .count(count2), .tc(tc2), .wrap(wrap2));
    bcd_count #(.NUM_DIGITS(3)) dut3 (.clk(clk), .rst(rst3), .count(count3), .tc(tc3), .wrap(wrap3));

    always #5 clk = ~clk;

    int   checks   = 0;
    int   failures = 0;
    int   mv[3];
    bit   mw[3];
    bit   inj[3];
    int   md[3]    = '{10, 100, 1000};
    int   wraps3   = 0;
    logic [7:0] prev2 = 8'h00;
    bit   s0910    = 1'b0;
    bit   s9900    = 1'b0;

    function automatic logic [31:0] to_bcd(input int v);
        logic [31:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic nibbles_legal(input logic [31:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (v[4*i +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("cnt1", 32'(count1), to_bcd(mv[0]));
        chk("tc1",  32'(tc1),    32'(mv[0] == md[0] - 1));
        chk("wrap1", 32'(wrap1), 32'(mw[0]));
        chk("cnt2", 32'(count2), to_bcd(mv[1]));
        chk("tc2",  32'(tc2),    32'(mv[1] == md[1] - 1));
        chk("wrap2", 32'(wrap2), 32'(mw[1]));
        chk("cnt3", 32'(count3), to_bcd(mv[2]));
        chk("tc3",  32'(tc3),    32'(mv[2] == md[2] - 1));
        chk("wrap3", 32'(wrap3), 32'(mw[2]));
        chk("nib2", 32'(nibbles_legal(32'(count2))), 32'd1);
        chk("nib3", 32'(nibbles_legal(32'(count3))), 32'd1);
        if (prev2 == 8'h09 && count2 == 8'h10) s0910 = 1'b1;
        if (prev2 == 8'h99 && count2 == 8'h00) s9900 = 1'b1;
        prev2 = count2;
        if (wrap3) wraps3++;
    endtask

    // Advance the model on the edge, check on the following falling edge
    task automatic tick();
        logic r;
        @(posedge clk);
        for (int d = 0; d < 3; d++) begin
            r = (d == 0) ? rst1 : (d == 1) ? rst2 : rst3;
            if (!r) begin
                mv[d] = 0;
                mw[d] = 1'b0;
            end else if (inj[d]) begin
                mv[d]  = (mv[d] / 10) * 10;
                mw[d]  = 1'b0;
                inj[d] = 1'b0;
            end else begin
                mw[d] = (mv[d] == md[d] - 1);
                mv[d] = (mv[d] + 1) % md[d];
            end
        end
        @(negedge clk);
        check_all();
    endtask

    initial begin
        int n;
        rst1 = 1'b0; rst2 = 1'b0; rst3 = 1'b0;
        for (int d = 0; d < 3; d++) begin
            mv[d] = 0; mw[d] = 1'b0; inj[d] = 1'b0;
        end

        // Reset hold with clock running
        repeat (50) tick();

        // Release all together; 1-digit count 1..9,0,1,2
        rst1 = 1'b1; rst2 = 1'b1; rst3 = 1'b1;
        repeat (12) tick();
        chk("d1_after12", 32'(count1), 32'h2);

        // Async reset between edges at count 6
        n = 0;
        while (mv[0] != 6 && n < 20) begin
            tick();
            n++;
        end
        chk("reach6", 32'(count1), 32'h6);
        #2 rst1 = 1'b0;
        #1;
        mv[0] = 0; mw[0] = 1'b0;
        chk("async_cnt",  32'(count1), 32'h0);
        chk("async_tc",   32'(tc1),    32'h0);
        chk("async_wrap", 32'(wrap1),  32'h0);
        tick();
        rst1 = 1'b1;
        tick();
        chk("resume1", 32'(count1), 32'h1);
        tick();
        chk("resume2", 32'(count1), 32'h2);

        // Cascade: cover a full 2-digit cycle with a random extra tail
        n = 110 + int'($urandom_range(0, 20));
        repeat (n) tick();
        chk("seen_09_10", 32'(s0910), 32'd1);
        chk("seen_99_00", 32'(s9900), 32'd1);

        // Illegal code in digit 0 of the 2-digit counter
        repeat (int'($urandom_range(1, 9))) tick();
        force dut2.g_digit[0].u_digit.digit_q = 4'hC;
        #1;
        chk("forced_nib", 32'(count2[3:0]), 32'hC);
        chk("forced_tc",  32'(tc2),         32'h0);
        release dut2.g_digit[0].u_digit.digit_q;
        inj[1] = 1'b1;
        tick();
        chk("recover_d0", 32'(count2[3:0]), 32'h0);
        repeat (5) tick();

        // Long run on the 3-digit counter from a fresh reset
        #2 rst3 = 1'b0;
        #1;
        mv[2] = 0; mw[2] = 1'b0;
        tick();
        rst3 = 1'b1;
        wraps3 = 0;
        repeat (2500) tick();
        chk("long_cnt",   32'(count3), 32'h500);
        chk("long_wraps", 32'(wraps3), 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
